// File: rtl/sha_final_padding_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sha_final_padding_param
//  Purpose  : Final-block padder for the SHA-2 family. Sits between a host
//             and a SHA-2 core. Init strobes and full blocks pass straight
//             through. On a final block it masks the message tail, appends
//             the '1' marker bit and the big-endian message length. It then
//             issues one or two block strobes to the core.
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             init_in / init_out   - start of message (mirrored to core)
//             next_in              - full message block on block_in
//             final_in, final_len  - last block and its bit count (MSB-aligned)
//             block_in             - host block, bit BLOCK_W-1 = first bit
//             core_ready           - core idle / digest valid
//             next_out, block_out  - block strobe and data to the core
//             ready_out            - ready indication to the host
//  Revision : 1.0 - initial release
// ============================================================================
module sha_final_padding_param #(
    parameter int BLOCK_W = 512,
    parameter int LEN_W   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init_in,
    input  logic                     next_in,
    input  logic                     final_in,
    input  logic [$clog2(BLOCK_W):0] final_len,
    input  logic [BLOCK_W-1:0]       block_in,
    input  logic                     core_ready,
    output logic                     init_out,
    output logic                     next_out,
    output logic                     ready_out,
    output logic [BLOCK_W-1:0]       block_out
);

    localparam int c_CNT_W = $clog2(BLOCK_W) + 1;
    localparam logic [c_CNT_W-1:0] c_BLK_BITS = c_CNT_W'(BLOCK_W);
    // Longest tail that still leaves room for the marker bit and length field.
    localparam logic [c_CNT_W-1:0] c_FIT_MAX  = c_CNT_W'(BLOCK_W - LEN_W - 1);
    localparam logic [LEN_W-1:0]   c_BLK_INC  = LEN_W'(BLOCK_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEXT1 = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_NEXT2 = 3'd3,
        ST_WAIT2 = 3'd4
    } state_t;

    state_t               r_state;
    logic [LEN_W-1:0]     r_bit_ctr;
    logic [BLOCK_W-1:0]   r_blk1;
    logic [BLOCK_W-1:0]   r_blk2;
    logic                 r_two_blk;
    logic                 r_guard;

    logic [c_CNT_W-1:0]   w_len;
    logic [LEN_W-1:0]     w_total;
    logic [BLOCK_W-1:0]   w_keep;
    logic [BLOCK_W-1:0]   w_one;
    logic [BLOCK_W-1:0]   w_body;
    logic                 w_fits;
    logic [BLOCK_W-1:0]   w_blk1;
    logic [BLOCK_W-1:0]   w_blk2;

    // Padding datapath, evaluated from the live host inputs in IDLE.
    always_comb begin
        w_len   = (final_len > c_BLK_BITS) ? c_BLK_BITS : final_len;
        w_total = (init_in ? '0 : r_bit_ctr) + {{(LEN_W-c_CNT_W){1'b0}}, w_len};
        // Keep the top w_len bits; a shift by BLOCK_W yields all-zero, so a
        // full block keeps everything and gets no marker bit.
        w_keep  = ~({BLOCK_W{1'b1}} >> w_len);
        w_one   = {1'b1, {(BLOCK_W-1){1'b0}}} >> w_len;
        w_body  = (block_in & w_keep) | w_one;
        w_fits  = (w_len <= c_FIT_MAX);
        w_blk1  = w_fits ? {w_body[BLOCK_W-1:LEN_W], w_total} : w_body;
        // Overflow block: marker bit only when the tail filled block 1 exactly.
        w_blk2  = {(w_len == c_BLK_BITS), {(BLOCK_W-LEN_W-1){1'b0}}, w_total};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_ctr <= '0;
            r_blk1    <= '0;
            r_blk2    <= '0;
            r_two_blk <= 1'b0;
            r_guard   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (final_in) begin
                        // A next_in in the same cycle is deliberately dropped.
                        r_bit_ctr <= w_total;
                        r_blk1    <= w_blk1;
                        if (!w_fits) begin
                            r_blk2 <= w_blk2;
                        end
                        r_two_blk <= ~w_fits;
                        r_state   <= ST_NEXT1;
                    end else if (next_in) begin
                        r_bit_ctr <= (init_in ? '0 : r_bit_ctr) + c_BLK_INC;
                    end else if (init_in) begin
                        r_bit_ctr <= '0;
                    end
                end
                ST_NEXT1: begin
                    r_guard <= 1'b1;
                    r_state <= ST_WAIT1;
                end
                ST_WAIT1: begin
                    // The core may still report ready in the cycle right after
                    // the strobe, so the first WAIT cycle ignores core_ready.
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (core_ready) begin
                        r_state <= r_two_blk ? ST_NEXT2 : ST_IDLE;
                    end
                end
                ST_NEXT2: begin
                    r_guard <= 1'b1;
                    r_state <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (core_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs: pass-through in IDLE, driven from the padded registers otherwise.
    always_comb begin
        init_out  = init_in;
        next_out  = 1'b0;
        ready_out = 1'b0;
        block_out = block_in;
        case (r_state)
            ST_IDLE: begin
                next_out  = next_in & ~final_in;
                ready_out = core_ready & ~final_in;
                block_out = block_in;
            end
            ST_NEXT1: begin
                next_out  = 1'b1;
                block_out = r_blk1;
            end
            ST_WAIT1: begin
                block_out = r_blk1;
            end
            ST_NEXT2: begin
                next_out  = 1'b1;
                block_out = r_blk2;
            end
            ST_WAIT2: begin
                block_out = r_blk2;
            end
            default: begin
                block_out = block_in;
            end
        endcase
        if (reset) begin
            next_out  = 1'b0;
            ready_out = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha_final_padding_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sha_final_padding_param
//  Purpose  : Self-checking bench for sha_final_padding_param. One instance
//             per block width (512/64 and 1024/128); a select picks which
//             instance is driven, the other sees idle inputs. Expected blocks
//             come from a bit-level padding model of the message.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha_final_padding_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        init_v, next_v, fin_v, cr_v;
    logic [10:0] flen_v;
    logic [1023:0] blk_v;

    logic        d0_init_out, d0_next_out, d0_ready_out;
    logic [511:0] d0_block_out;
    logic        d1_init_out, d1_next_out, d1_ready_out;
    logic [1023:0] d1_block_out;

    sha_final_padding_param #(.BLOCK_W(512), .LEN_W(64)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .init_in    (init_v & ~sel),
        .next_in    (next_v & ~sel),
        .final_in   (fin_v & ~sel),
        .final_len  (flen_v[9:0]),
        .block_in   (blk_v[511:0]),
        .core_ready (cr_v | sel),
        .init_out   (d0_init_out),
        .next_out   (d0_next_out),
        .ready_out  (d0_ready_out),
        .block_out  (d0_block_out)
    );

    sha_final_padding_param #(.BLOCK_W(1024), .LEN_W(128)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .init_in    (init_v & sel),
        .next_in    (next_v & sel),
        .final_in   (fin_v & sel),
        .final_len  (flen_v),
        .block_in   (blk_v),
        .core_ready (cr_v | ~sel),
        .init_out   (d1_init_out),
        .next_out   (d1_next_out),
        .ready_out  (d1_ready_out),
        .block_out  (d1_block_out)
    );

    logic          o_init, o_next, o_ready;
    logic [1023:0] o_blk;
    assign o_init  = sel ? d1_init_out  : d0_init_out;
    assign o_next  = sel ? d1_next_out  : d0_next_out;
    assign o_ready = sel ? d1_ready_out : d0_ready_out;
    assign o_blk   = sel ? d1_block_out : {512'b0, d0_block_out};

    int n_chk  = 0;
    int n_fail = 0;
    logic [127:0] mctr [2];   // model of message bit count per instance

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        check(tag, {255'b0, got}, {255'b0, exp});
    endtask

    task automatic chk_blk(input string tag, input logic [1023:0] got,
                           input logic [1023:0] exp, input int bw);
        for (int c = 0; c < bw / 256; c++) begin
            check($sformatf("%s[%0d]", tag, c), got[c*256 +: 256], exp[c*256 +: 256]);
        end
    endtask

    function automatic int bw_of(input logic s);
        return s ? 1024 : 512;
    endfunction

    function automatic int lw_of(input logic s);
        return s ? 128 : 64;
    endfunction

    function automatic logic [127:0] wrap(input logic [127:0] v, input int lw);
        logic [127:0] m;
        m = (lw >= 128) ? {128{1'b1}} : ((128'd1 << lw) - 128'd1);
        return v & m;
    endfunction

    function automatic logic [1023:0] rnd_blk();
        logic [1023:0] v;
        for (int k = 0; k < 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Message-level padding: keep the first L message bits, a '1', zeros, and
    // the total length in the last lw bits of the final block of the message.
    task automatic pad_model(input int bw, input int lw, input logic [127:0] base,
                             input int len, input logic [1023:0] blk,
                             output logic [1023:0] b1, output logic [1023:0] b2,
                             output bit two, output logic [127:0] t);
        t  = wrap(base + 128'(len), lw);
        b1 = '0;
        b2 = '0;
        for (int i = 0; i < len; i++) b1[bw-1-i] = blk[bw-1-i];
        if (len < bw) b1[bw-1-len] = 1'b1;
        two = (len + 1 + lw > bw);
        if (!two) begin
            for (int j = 0; j < lw; j++) b1[j] = t[j];
        end else begin
            if (len == bw) b2[bw-1] = 1'b1;
            for (int j = 0; j < lw; j++) b2[j] = t[j];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init();
        init_v = 1'b1;
        @(negedge clk);
        chk1("init_mirror", o_init, 1'b1);
        chk1("init_no_next", o_next, 1'b0);
        step();
        mctr[sel] = '0;
        init_v = 1'b0;
    endtask

    task automatic do_next(input logic with_init);
        logic crv;
        int   bw;
        bw     = bw_of(sel);
        crv    = 1'($urandom_range(0, 1));
        init_v = with_init;
        next_v = 1'b1;
        cr_v   = crv;
        blk_v  = rnd_blk();
        @(negedge clk);
        chk1("next_pass", o_next, 1'b1);
        chk1("next_ready", o_ready, crv);
        chk1("next_init", o_init, with_init);
        chk_blk("next_blk", o_blk, blk_v, bw);
        step();
        mctr[sel] = wrap((with_init ? 128'd0 : mctr[sel]) + 128'(bw), lw_of(sel));
        init_v = 1'b0;
        next_v = 1'b0;
        cr_v   = 1'b1;
    endtask

    // One WAIT phase: core_ready rises k cycles in; exit needs ready after the
    // first cycle. Optionally pokes host controls that must be ignored.
    task automatic wait_phase(input string tag, input logic [1023:0] exp,
                              input int k, input bit inject, input int bw);
        bit done;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            cr_v   = (i >= k);
            next_v = inject && (i == 0);
            init_v = inject && (i == 0);
            fin_v  = inject && (i == 1);
            @(negedge clk);
            chk1({tag, "_next"}, o_next, 1'b0);
            chk1({tag, "_ready"}, o_ready, 1'b0);
            if (inject && i == 0) chk1({tag, "_init_mirror"}, o_init, 1'b1);
            chk_blk({tag, "_blk"}, o_blk, exp, bw);
            done = (i >= 1) && cr_v;
            step();
        end
        next_v = 1'b0;
        init_v = 1'b0;
        fin_v  = 1'b0;
        chk1({tag, "_exit"}, done, 1'b1);
    endtask

    task automatic do_final(input logic with_init, input int flen, input logic [1023:0] blk,
                            input logic with_next, input int k, input bit inject);
        int bw, lw, len;
        logic [1023:0] b1, b2;
        bit two;
        logic [127:0] t;
        bw  = bw_of(sel);
        lw  = lw_of(sel);
        len = (flen > bw) ? bw : flen;
        pad_model(bw, lw, with_init ? 128'd0 : mctr[sel], len, blk, b1, b2, two, t);
        init_v = with_init;
        fin_v  = 1'b1;
        next_v = with_next;
        flen_v = 11'(flen);
        blk_v  = blk;
        cr_v   = 1'b1;
        @(negedge clk);
        chk1("fin_next", o_next, 1'b0);
        chk1("fin_ready", o_ready, 1'b0);
        step();
        mctr[sel] = t;
        init_v = 1'b0;
        fin_v  = 1'b0;
        next_v = 1'b0;
        blk_v  = rnd_blk();
        cr_v   = (k == 0);
        @(negedge clk);
        chk1("next1", o_next, 1'b1);
        chk1("next1_ready", o_ready, 1'b0);
        chk_blk("blk1", o_blk, b1, bw);
        step();
        wait_phase("wait1", b1, k, inject, bw);
        if (two) begin
            cr_v = (k == 0);
            @(negedge clk);
            chk1("next2", o_next, 1'b1);
            chk1("next2_ready", o_ready, 1'b0);
            chk_blk("blk2", o_blk, b2, bw);
            step();
            wait_phase("wait2", b2, k, 1'b0, bw);
        end
        cr_v  = 1'b1;
        blk_v = rnd_blk();
        @(negedge clk);
        chk1("idle_ready", o_ready, 1'b1);
        chk1("idle_next", o_next, 1'b0);
        chk_blk("idle_pass", o_blk, blk_v, bw);
        step();
    endtask

    // Abort a two-block final in WAIT1 with reset.
    task automatic do_reset_mid();
        int bw;
        bw     = bw_of(sel);
        init_v = 1'b1;
        fin_v  = 1'b1;
        flen_v = 11'(bw);
        blk_v  = rnd_blk();
        step();
        init_v = 1'b0;
        fin_v  = 1'b0;
        cr_v   = 1'b0;
        @(negedge clk);
        chk1("rst_next1", o_next, 1'b1);
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        chk1("rst_hold_next", o_next, 1'b0);
        chk1("rst_hold_ready", o_ready, 1'b0);
        step();
        reset = 1'b0;
        cr_v  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("rst_idle_ready", o_ready, 1'b1);
            chk1("rst_no_next2", o_next, 1'b0);
            step();
        end
        mctr[0] = '0;
        mctr[1] = '0;
    endtask

    function automatic int pick_len(input logic s);
        int bw, lw, mx;
        bw = bw_of(s);
        lw = lw_of(s);
        mx = s ? 2047 : 1023;
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return bw - lw - 1;
            2:       return bw - lw;
            3:       return bw;
            4:       return int'($urandom_range(bw + 1, mx));
            default: return int'($urandom_range(0, bw));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] b;
        reset  = 1'b1;
        sel    = 1'b0;
        init_v = 1'b0;
        next_v = 1'b0;
        fin_v  = 1'b0;
        cr_v   = 1'b1;
        flen_v = '0;
        blk_v  = '0;
        mctr[0] = '0;
        mctr[1] = '0;
        step();
        step();
        next_v = 1'b1;
        @(negedge clk);
        chk1("reset_next", o_next, 1'b0);
        chk1("reset_ready", o_ready, 1'b0);
        step();
        next_v = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        chk1("post_reset_ready", o_ready, 1'b1);
        chk1("post_reset_next", o_next, 1'b0);
        step();

        // "abc" with a dirty tail
        do_init();
        b = '0;
        b[511:0] = {24'h616263, {488{1'b1}}};
        do_final(1'b0, 24, b, 1'b0, 2, 1'b0);
        // two-block case
        do_final(1'b1, 448, rnd_blk(), 1'b0, 1, 1'b0);
        // one full block then a full final block
        do_init();
        do_next(1'b0);
        do_final(1'b0, 512, rnd_blk(), 1'b0, 3, 1'b0);
        // longest single-block tail and saturated length
        do_final(1'b1, 447, rnd_blk(), 1'b0, 1, 1'b0);
        do_final(1'b1, 600, rnd_blk(), 1'b0, 2, 1'b0);
        // 1024-bit instance, empty tail, core_ready held high
        sel = 1'b1;
        do_final(1'b1, 0, rnd_blk(), 1'b0, 0, 1'b0);
        // dropped next_in, ignored controls in WAIT, counter carried forward
        sel = 1'b0;
        do_final(1'b1, 100, rnd_blk(), 1'b1, 1, 1'b1);
        do_final(1'b0, 200, rnd_blk(), 1'b0, 2, 1'b0);
        do_reset_mid();
        do_final(1'b0, 37, rnd_blk(), 1'b0, 1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            sel = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       do_init();
                1:       do_next(1'($urandom_range(0, 1)));
                default: do_final(1'($urandom_range(0, 1)), pick_len(sel), rnd_blk(),
                                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                                  1'($urandom_range(0, 1)));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
